spike_rate_monitor: RTL and testbench
=====================================

# spike_rate_monitor

Downstream consumer of the LIF/RNN neuron stage: it takes the neuron's spike bit and converts it into a windowed firing-rate count, a last inter-spike-interval (ISI) measurement and a burst flag. The rate result is delivered through a valid/ready handshake with a sticky overrun flag. The block sits between the neuron output and the readout/IO logic of the tile, all in the single tile clock domain.

## Interface
- `WIN_LOG_BASE`, default 6: the window length is N = 2^(WIN_LOG_BASE + win_sel) cycles.
- `BURST_ISI`, default 4: an ISI at or below this value flags a burst.
- `clk` input 1: tile clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `en` input 1: run enable. 1 = measure; 0 = idle, any partial window is discarded.
- `spike_in` input 1: neuron spike bit, bit 7 of the neuron output byte. Level input; only its rising edges count.
- `win_sel` input 2: window select, giving N = 64/128/256/512 at defaults.
- `rate` output 8: spike count of the last completed window, saturating at 255.
- `rate_valid` output 1: `rate` holds an unconsumed result.
- `rate_ready` input 1: consumer accepts `rate` this cycle.
- `overrun` output 1: sticky; a window completed while the previous result was still unconsumed.
- `isi` output 8: cycles between the last two spike events, saturating at 255.
- `burst` output 1: the last event had ISI ≤ `BURST_ISI`.

## Operation
- **Reset** (`rst_n`=0 at an edge): state=IDLE, `spike_q`=0, `acc`=0, `win_cnt`=0, `isi_cnt`=255.
  - Outputs: `rate`=0, `rate_valid`=0, `overrun`=0, `isi`=0, `burst`=0.
  - Reset has priority over every other action, including mid-window.
- **Edge detect**: `event = spike_in & ~spike_q`. `spike_q <= spike_in` every cycle, including in IDLE. A spike that is already high when `en` rises is therefore not counted.
- **IDLE**: when `en`=1, load `win_cnt` = N−1 using the current `win_sel`, clear `acc`, and go to RUN. The event in this cycle is ignored. `isi_cnt` holds its value.
- **RUN with `en`=0**: go to IDLE. Discard `acc`. `rate`, `rate_valid`, `overrun`, `isi` and `burst` are retained.
- **RUN, `win_cnt` ≠ 0**: `acc <= sat255(acc + event)`; `win_cnt` decrements.
- **RUN, `win_cnt` = 0 (last window cycle)**:
  - `rate <= sat255(acc + event)` and `rate_valid <= 1`.
  - `acc <= 0`; `win_cnt` reloads to N−1, re-sampling `win_sel`. Windows run back-to-back with no gap.
- **Handshake**: a transfer occurs when `rate_valid & rate_ready`.
  - After a transfer, `rate_valid` clears at the next edge, unless a window completes in that same cycle; then `rate_valid` stays 1 with the new `rate`.
  - `rate_ready` while `rate_valid`=0 has no effect.
- **Overrun**:
  - Set when a window completes while `rate_valid`=1 and `rate_ready`=0. The new value overwrites `rate`.
  - Cleared on a transfer cycle unless set in the same cycle; set wins.
  - Only reset also clears it.
- **ISI** (RUN only):
  - On an event: `isi <= isi_cnt`, `burst <= (isi_cnt ≤ BURST_ISI)`, `isi_cnt <= 1`.
  - Otherwise: `isi_cnt <= sat255(isi_cnt + 1)`.
  - The first event after reset reports `isi`=255.
- **Arithmetic**: all counters are 8-bit and unsigned; `win_cnt` is 10-bit; saturation is checked before the register write.

## Timing
- `en` sampled 1 at edge k (state IDLE) → RUN window covers the cycles sampled at edges k+1 … k+N.
- `rate_valid` rises at edge k+N. Each following window ends N edges later.
- Rate latency: a spike event is reflected in `rate` at the window-end edge, i.e. 0–(N−1) cycles after the event.
- ISI latency: `isi` and `burst` update at the same edge that samples the event.
- Minimum ISI is 2, because a rising edge needs a low cycle between events.
- A `win_sel` change mid-window takes effect only at the next reload.

## Test plan
- **Nominal rate and ISI**: reset, `win_sel`=0, `en`=1, 1-cycle spikes every 4 cycles, `rate_ready`=1 → each window `rate`=16, `rate_valid` pulses for 1 cycle every 64 cycles, `isi`=4, `burst`=1.
- **Saturation**: `win_sel`=3 (N=512), `spike_in` toggling every cycle (256 events) → `rate`=255. After a gap of 300 idle cycles in RUN, the next spike gives `isi`=255 and `burst`=0.
- **Handshake and overrun**:
  - `rate_ready`=0 for two windows → `rate_valid` stays 1, second window sets `overrun`=1 and `rate` holds the second count.
  - `rate_ready`=1 for one cycle → `rate_valid` and `overrun` clear.
  - `rate_ready` asserted exactly on a window-end cycle → `rate_valid` stays 1 and `overrun` stays 0.
- **Enable abort**: drop `en` 20 cycles into a window containing 3 events → `rate` is unchanged. Re-enable → the new window starts from `acc`=0, and a spike held high across the re-enable is not counted.
- **Reset mid-window**: assert `rst_n`=0 for 1 cycle with `rate_valid`=1 and `overrun`=1 → all outputs return to reset values at that edge. The first post-reset event gives `isi`=255.

Source files
------------

// File: rtl/spike_rate_monitor_if.sv
// Result bus of the spike rate monitor: windowed rate with valid/ready and overrun,
// plus the ISI and burst measurements that ride alongside it.
interface spike_rate_monitor_if;
  logic [7:0] rate;
  logic       rate_valid;
  logic       rate_ready;
  logic       overrun;
  logic [7:0] isi;
  logic       burst;

  modport master (
    output rate, rate_valid, overrun, isi, burst,
    input  rate_ready
  );

  modport slave (
    input  rate, rate_valid, overrun, isi, burst,
    output rate_ready
  );
endinterface

// File: rtl/spike_rate_monitor.sv
// Converts the neuron spike bit into a windowed firing-rate count, last inter-spike
// interval and burst flag; the rate is handed off over valid/ready with sticky overrun.
module spike_rate_monitor #(
  parameter int WIN_LOG_BASE = 6,
  parameter int BURST_ISI    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       spike_in,
  input  logic [1:0] win_sel,
  spike_rate_monitor_if.master rbus
);

  localparam logic [7:0] BURST_TH = 8'(BURST_ISI);

  typedef enum logic {IDLE, RUN} state_t;

  // Terminal count for the selected window: N-1 with N = 2^(WIN_LOG_BASE+sel).
  function automatic logic [9:0] win_last(input logic [1:0] sel);
    logic [10:0] n;
    n = 11'd1 << (WIN_LOG_BASE + int'(sel));
    return 10'(n - 11'd1);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    return (v == 8'hFF) ? v : v + {7'd0, inc};
  endfunction

  state_t     state;
  logic       spike_q;
  logic [7:0] acc;
  logic [9:0] win_cnt;
  logic [7:0] isi_cnt;
  logic [7:0] rate;
  logic       rate_valid;
  logic       overrun;
  logic [7:0] isi;
  logic       burst;

  logic ev;
  logic xfer;
  logic win_done;
  logic ovr_set;

  assign ev       = spike_in & ~spike_q;
  assign xfer     = rate_valid & rbus.rate_ready;
  assign win_done = (state == RUN) & en & (win_cnt == 10'd0);
  // A completion while the previous result is still pending and not being taken.
  assign ovr_set  = win_done & rate_valid & ~rbus.rate_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      spike_q    <= 1'b0;
      acc        <= 8'd0;
      win_cnt    <= 10'd0;
      isi_cnt    <= 8'hFF;
      rate       <= 8'd0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
      isi        <= 8'd0;
      burst      <= 1'b0;
    end else begin
      spike_q <= spike_in;

      if (win_done)  rate_valid <= 1'b1;
      else if (xfer) rate_valid <= 1'b0;

      if (ovr_set)   overrun <= 1'b1;
      else if (xfer) overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (en) begin
            win_cnt <= win_last(win_sel);
            acc     <= 8'd0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
            acc   <= 8'd0;
          end else begin
            if (ev) begin
              isi     <= isi_cnt;
              burst   <= (isi_cnt <= BURST_TH);
              isi_cnt <= 8'd1;
            end else begin
              isi_cnt <= sat_inc(isi_cnt, 1'b1);
            end

            if (win_cnt != 10'd0) begin
              acc     <= sat_inc(acc, ev);
              win_cnt <= win_cnt - 10'd1;
            end else begin
              // Windows run back-to-back; win_sel is re-sampled only here.
              rate    <= sat_inc(acc, ev);
              acc     <= 8'd0;
              win_cnt <= win_last(win_sel);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rbus.rate       = rate;
  assign rbus.rate_valid = rate_valid;
  assign rbus.overrun    = overrun;
  assign rbus.isi        = isi;
  assign rbus.burst      = burst;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed bench for spike_rate_monitor: expected window results are queued as the
// spike pattern is driven and checked against each valid/ready transfer.
module tb_spike_rate_monitor;
  logic       clk;
  logic       rst_n;
  logic       en;
  logic       spike_in;
  logic [1:0] win_sel;

  spike_rate_monitor_if rif ();

  spike_rate_monitor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .spike_in (spike_in),
    .win_sel  (win_sel),
    .rbus     (rif.master)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Transfer monitor: inputs change at the falling edge, so 2 time units later
  // valid/ready show exactly what the next rising edge will see.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && rif.rate_valid && rif.rate_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL xfer_unexpected observed=%0d expected=none", rif.rate);
      end else begin
        chk("xfer_rate", {24'd0, rif.rate}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int vcount;
    rst_n = 1'b0; en = 1'b0; spike_in = 1'b0; win_sel = 2'd0;
    rif.rate_ready = 1'b0;
    repeat (3) tick();
    chk("rst_rate",       rif.rate,       0);
    chk("rst_rate_valid", rif.rate_valid, 0);
    chk("rst_overrun",    rif.overrun,    0);
    chk("rst_isi",        rif.isi,        0);
    chk("rst_burst",      rif.burst,      0);

    // Nominal: N=64, spikes every 4 cycles, consumer always ready.
    rst_n = 1'b1;
    rif.rate_ready = 1'b1;
    repeat (3) exp_q.push_back(8'd16);
    vcount = 0;
    for (int t = 0; t <= 192; t++) begin
      en = 1'b1;
      spike_in = (t % 4 == 0);
      tick();
      if (rif.rate_valid) vcount++;
      if (t == 4) begin
        chk("nom_first_isi",   rif.isi,   255);
        chk("nom_first_burst", rif.burst, 0);
      end
    end
    chk("nom_valid_pulses", vcount,      3);
    chk("nom_rate",         rif.rate,    16);
    chk("nom_isi",          rif.isi,     4);
    chk("nom_burst",        rif.burst,   1);
    chk("nom_overrun",      rif.overrun, 0);
    en = 1'b0; spike_in = 1'b0;
    repeat (2) tick();

    // Saturation: N=512 with 256 events, then a long silent gap in RUN.
    win_sel = 2'd3;
    exp_q.push_back(8'd255);
    for (int t = 0; t <= 512; t++) begin
      en = 1'b1;
      spike_in = (t % 2 == 0);
      tick();
    end
    chk("sat_rate",  rif.rate,  255);
    chk("sat_isi",   rif.isi,   2);
    chk("sat_burst", rif.burst, 1);
    spike_in = 1'b0;
    repeat (300) tick();
    spike_in = 1'b1;
    tick();
    chk("gap_isi",   rif.isi,   255);
    chk("gap_burst", rif.burst, 0);
    spike_in = 1'b0; en = 1'b0;
    repeat (2) tick();
    chk("sat_abort_rate",  rif.rate,       255);
    chk("sat_abort_valid", rif.rate_valid, 0);

    // Handshake and overrun: two windows with nobody consuming.
    win_sel = 2'd0;
    rif.rate_ready = 1'b0;
    exp_q.push_back(8'd16);
    for (int t = 0; t <= 64; t++) begin
      en = 1'b1;
      spike_in = (t % 8 == 0);
      tick();
    end
    chk("hs_w1_valid",   rif.rate_valid, 1);
    chk("hs_w1_overrun", rif.overrun,    0);
    chk("hs_w1_rate",    rif.rate,       8);
    for (int t = 65; t <= 128; t++) begin
      spike_in = (t % 4 == 0);
      tick();
    end
    chk("hs_w2_valid",   rif.rate_valid, 1);
    chk("hs_w2_overrun", rif.overrun,    1);
    chk("hs_w2_rate",    rif.rate,       16);
    spike_in = 1'b0;
    rif.rate_ready = 1'b1;
    tick();
    rif.rate_ready = 1'b0;
    chk("hs_take_valid",   rif.rate_valid, 0);
    chk("hs_take_overrun", rif.overrun,    0);

    // Ready asserted exactly on the cycle another window completes.
    exp_q.push_back(8'd4);
    for (int t = 130; t <= 192; t++) begin
      spike_in = (t % 16 == 0);
      tick();
    end
    chk("hs_w3_valid", rif.rate_valid, 1);
    for (int t = 193; t <= 256; t++) begin
      spike_in = (t % 32 == 0);
      if (t == 256) rif.rate_ready = 1'b1;
      tick();
    end
    rif.rate_ready = 1'b0;
    chk("hs_edge_valid",   rif.rate_valid, 1);
    chk("hs_edge_overrun", rif.overrun,    0);
    chk("hs_edge_rate",    rif.rate,       2);

    // Enable abort 20 cycles into a window holding 3 events.
    for (int t = 257; t <= 276; t++) begin
      spike_in = (t == 260 || t == 265 || t == 270);
      tick();
    end
    en = 1'b0; spike_in = 1'b0;
    repeat (4) tick();
    chk("abort_rate",    rif.rate,       2);
    chk("abort_valid",   rif.rate_valid, 1);
    chk("abort_overrun", rif.overrun,    0);
    exp_q.push_back(8'd2);
    rif.rate_ready = 1'b1;
    tick();
    chk("abort_drain_valid", rif.rate_valid, 0);

    // Re-enable with the spike rising on the enable cycle and held high.
    exp_q.push_back(8'd3);
    for (int j = 0; j <= 64; j++) begin
      en = 1'b1;
      spike_in = (j <= 9) || (j == 20) || (j == 30) || (j == 40);
      tick();
    end
    chk("reen_rate",  rif.rate,       3);
    chk("reen_valid", rif.rate_valid, 1);
    spike_in = 1'b0;
    tick();
    chk("reen_valid_clr", rif.rate_valid, 0);

    // Reset mid-window with a pending result and overrun set.
    en = 1'b0;
    repeat (2) tick();
    rif.rate_ready = 1'b0;
    for (int t = 0; t <= 150; t++) begin
      en = 1'b1;
      spike_in = (t % 8 == 0);
      tick();
    end
    chk("pre_rst_valid",   rif.rate_valid, 1);
    chk("pre_rst_overrun", rif.overrun,    1);
    rst_n = 1'b0; spike_in = 1'b0;
    tick();
    chk("mid_rst_rate",       rif.rate,       0);
    chk("mid_rst_rate_valid", rif.rate_valid, 0);
    chk("mid_rst_overrun",    rif.overrun,    0);
    chk("mid_rst_isi",        rif.isi,        0);
    chk("mid_rst_burst",      rif.burst,      0);
    rst_n = 1'b1;
    repeat (2) tick();
    spike_in = 1'b1;
    tick();
    chk("post_rst_isi",   rif.isi,   255);
    chk("post_rst_burst", rif.burst, 0);
    spike_in = 1'b0; en = 1'b0;
    repeat (2) tick();

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
